// File: rtl/rand_pkg.sv
// ============================================================================
//  Package     : rand_pkg
//  Description : Shared debounce state type, blank-digit code and hex decoder
//                for the random-value capture display.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rand_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FILT_PRESS = 2'd1,
        HELD       = 2'd2,
        FILT_REL   = 2'd3
    } deb_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} segment pattern for one hex digit.
    function automatic logic [6:0] hex7seg(input logic [3:0] i_val);
        logic [6:0] w_seg;
        case (i_val)
            4'h0:    w_seg = 7'h40;
            4'h1:    w_seg = 7'h79;
            4'h2:    w_seg = 7'h24;
            4'h3:    w_seg = 7'h30;
            4'h4:    w_seg = 7'h19;
            4'h5:    w_seg = 7'h12;
            4'h6:    w_seg = 7'h02;
            4'h7:    w_seg = 7'h78;
            4'h8:    w_seg = 7'h00;
            4'h9:    w_seg = 7'h10;
            4'hA:    w_seg = 7'h08;
            4'hB:    w_seg = 7'h03;
            4'hC:    w_seg = 7'h46;
            4'hD:    w_seg = 7'h21;
            4'hE:    w_seg = 7'h06;
            default: w_seg = 7'h0E;
        endcase
        return w_seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchronizer plus press/release filter; emits a
//                single-cycle press_pulse once per accepted press.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module key_debounce
    import rand_pkg::*;
#(
    parameter int DEB_LIMIT = 1000000,
    parameter int DEB_W     = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press_pulse
);

    localparam logic [DEB_W-1:0] c_deb_last = DEB_W'(DEB_LIMIT - 1);

    logic             r_key_m;
    logic             r_key_s;
    deb_state_t       r_state;
    deb_state_t       w_state_nx;
    logic [DEB_W-1:0] r_cnt;
    logic [DEB_W-1:0] w_cnt_nx;
    logic             w_press;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_m <= 1'b0;
            r_key_s <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_key_m <= key;
            r_key_s <= r_key_m;
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_press    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nx = '0;
                if (r_key_s) w_state_nx = FILT_PRESS;
            end
            FILT_PRESS: begin
                if (!r_key_s) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_press    = 1'b1;
                    w_state_nx = HELD;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            HELD: begin
                w_cnt_nx = '0;
                if (!r_key_s) w_state_nx = FILT_REL;
            end
            FILT_REL: begin
                if (r_key_s) begin
                    w_state_nx = HELD;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Combinational so the top samples cq in the very cycle the filter completes.
    assign press_pulse = w_press;

endmodule

`default_nettype wire

// File: rtl/rand_capture_disp.sv
// ============================================================================
//  Module      : rand_capture_disp
//  Description : Captures the sequencer value on each debounced key press,
//                keeps a 4-deep history and scans it onto a 4-digit display.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rand_capture_disp
    import rand_pkg::*;
#(
    parameter int DEB_LIMIT = 1000000,
    parameter int DEB_W     = 20,
    parameter int SCAN_DIV  = 50000,
    parameter int SCAN_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cq,
    input  logic       key,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [3:0] hold_val,
    output logic [7:0] cap_cnt,
    output logic       cap_pulse
);

    localparam logic [SCAN_W-1:0] c_scan_last = SCAN_W'(SCAN_DIV - 1);

    logic              w_press;
    logic [3:0][3:0]   r_hist;
    logic [3:0]        r_valid;
    logic [7:0]        r_cnt;
    logic              r_pulse;
    logic [SCAN_W-1:0] r_div;
    logic [1:0]        r_idx;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;

    key_debounce #(
        .DEB_LIMIT (DEB_LIMIT),
        .DEB_W     (DEB_W)
    ) u_key_debounce (
        .clk         (clk),
        .rst         (rst),
        .key         (key),
        .press_pulse (w_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist  <= '0;
            r_valid <= '0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_div   <= '0;
            r_idx   <= '0;
            r_an    <= 4'b1110;
            r_seg   <= SEG_BLANK;
        end else begin
            r_pulse <= w_press;
            if (w_press) begin
                r_hist  <= {r_hist[2:0], cq};
                r_valid <= {r_valid[2:0], 1'b1};
                r_cnt   <= r_cnt + 8'd1;
            end

            if (r_div == c_scan_last) begin
                r_div <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end

            // an and seg come from the same index in the same edge, so they never skew.
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= r_valid[r_idx] ? hex7seg(r_hist[r_idx]) : SEG_BLANK;
        end
    end

    assign seg       = r_seg;
    assign an        = r_an;
    assign hold_val  = r_hist[0];
    assign cap_cnt   = r_cnt;
    assign cap_pulse = r_pulse;

endmodule

`default_nettype wire

// File: tb/tb_rand_capture_disp.sv
// ============================================================================
//  Module      : tb_rand_capture_disp
//  Description : Self-checking bench for rand_capture_disp with a run-length
//                debounce model and directed press/bounce/scan/wrap vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rand_capture_disp;

    localparam int DEB_LIMIT = 4;
    localparam int DEB_W     = 3;
    localparam int SCAN_DIV  = 2;
    localparam int SCAN_W    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cq  = 4'd0;
    logic       key = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic [3:0] hold_val;
    logic [7:0] cap_cnt;
    logic       cap_pulse;

    rand_capture_disp #(
        .DEB_LIMIT (DEB_LIMIT),
        .DEB_W     (DEB_W),
        .SCAN_DIV  (SCAN_DIV),
        .SCAN_W    (SCAN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cq        (cq),
        .key       (key),
        .seg       (seg),
        .an        (an),
        .hold_val  (hold_val),
        .cap_cnt   (cap_cnt),
        .cap_pulse (cap_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_pulses = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the key is accepted after DEB_LIMIT+1 consecutive synchronized
    // samples opposite to the current debounced level.
    bit         m_active = 0;
    bit         m_s1, m_s2, m_level, m_fire;
    int         m_run, m_tick, m_nvalid, m_idx;
    int         m_hist [4];
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_pulse;
    logic [7:0] e_cnt;
    logic [3:0] e_hold;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1;
            m_s1 = 0; m_s2 = 0; m_level = 0; m_run = 0; m_tick = 0; m_nvalid = 0;
            for (int i = 0; i < 4; i++) m_hist[i] = 0;
            e_an = 4'b1110; e_seg = 7'h7F; e_pulse = 0; e_cnt = 0; e_hold = 0;
        end else begin
            m_idx = (m_tick / SCAN_DIV) % 4;
            e_an  = ~(4'b0001 << m_idx);
            e_seg = (m_idx < m_nvalid) ? hex_tab[m_hist[m_idx]] : 7'h7F;
            m_tick++;
            m_fire = 0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == DEB_LIMIT + 1) begin
                    m_level = m_s2;
                    m_run   = 0;
                    m_fire  = m_s2;
                end
            end else begin
                m_run = 0;
            end
            e_pulse = m_fire;
            if (m_fire) begin
                for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
                m_hist[0] = int'(cq);
                if (m_nvalid < 4) m_nvalid++;
                e_cnt  = e_cnt + 8'd1;
                e_hold = cq;
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
    end

    always @(negedge clk) begin
        if (m_active) begin
            chk("m_an", an, e_an);
            chk("m_seg", seg, e_seg);
            chk("m_pulse", cap_pulse, e_pulse);
            chk("m_cnt", cap_cnt, e_cnt);
            chk("m_hold", hold_val, e_hold);
        end
        if (!rst && cap_pulse === 1'b1) n_pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cap_pulse !== 1'b1 && k < 40);
    endtask

    task automatic press(input logic [3:0] v);
        cq  = v;
        key = 1'b1;
        step(10);
        key = 1'b0;
        step(10);
    endtask

    // Samples 8 scan cycles; each digit must show its expected pattern.
    task automatic scan_check(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: chk({name, "_d0"}, seg, s0);
                4'b1101: chk({name, "_d1"}, seg, s1);
                4'b1011: chk({name, "_d2"}, seg, s2);
                4'b0111: chk({name, "_d3"}, seg, s3);
                default: chk({name, "_an"}, an, 4'b1110);
            endcase
        end
    endtask

    int lat, c0;

    initial begin
        // 1. reset
        step(3);
        chk("rst_an", an, 4'b1110);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_cnt", cap_cnt, 8'd0);
        chk("rst_hold", hold_val, 4'd0);
        chk("rst_pulse", cap_pulse, 1'b0);
        rst = 1'b0;
        scan_check("blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        // 2. clean press
        cq  = 4'd5;
        key = 1'b1;
        wait_pulse(lat);
        chk("press_latency", 8'(lat), 8'd7);
        step(13);
        key = 1'b0;
        step(12);
        chk("press_hold", hold_val, 4'd5);
        chk("press_cnt", cap_cnt, 8'd1);
        scan_check("press", 7'h12, 7'h7F, 7'h7F, 7'h7F);

        // 3. bounce rejection, then one stable press
        c0 = n_pulses;
        for (int i = 0; i < 5; i++) begin
            key = 1'b1; step(2);
            key = 1'b0; step(2);
        end
        step(10);
        chk("bounce_pulses", 8'(n_pulses - c0), 8'd0);
        chk("bounce_cnt", cap_cnt, 8'd1);
        press(4'd7);
        chk("bounce_then_press", 8'(n_pulses - c0), 8'd1);
        chk("press7_hold", hold_val, 4'd7);

        // 4. history shift
        press(4'd2); press(4'd5); press(4'd3); press(4'd4);
        chk("hist_hold", hold_val, 4'd4);
        chk("hist_cnt", cap_cnt, 8'd6);
        scan_check("hist", 7'h19, 7'h30, 7'h12, 7'h24);

        // 5. counter wrap
        rst = 1'b1; step(2); rst = 1'b0;
        c0 = n_pulses;
        for (int i = 0; i < 256; i++) press(4'(i));
        chk("wrap_cnt", cap_cnt, 8'd0);
        chk("wrap_pulses_lo", 8'(n_pulses - c0), 8'd0);
        chk("wrap_pulses_hi", 8'((n_pulses - c0) >> 8), 8'd1);
        press(4'd9);
        chk("wrap_cnt_257", cap_cnt, 8'd1);
        chk("wrap_hold", hold_val, 4'd9);

        // 6. reset mid-press, key held through release
        c0 = n_pulses;
        key = 1'b1;
        step(3);
        rst = 1'b1;
        step(3);
        chk("midrst_pulses", 8'(n_pulses - c0), 8'd0);
        chk("midrst_cnt", cap_cnt, 8'd0);
        chk("midrst_an", an, 4'b1110);
        rst = 1'b0;
        wait_pulse(lat);
        chk("midrst_latency", 8'(lat), 8'd7);
        step(2);
        chk("midrst_cap_cnt", cap_cnt, 8'd1);
        key = 1'b0;
        step(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
